inv_byte_permutation_unit: RTL
==============================

INV_BYTE_PERMUTATION_UNIT -- requirements
Module: inv_byte_permutation_unit

Interface
REQ-001 Parameter: INVERSE, default 1, 1 = InvShiftRows order, 0 = forward ShiftRows order.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 rst_synch  input  1  synchronous clear, active-high.
REQ-005 in_valid  input  1  in_byte carries a state byte.
REQ-006 in_byte  input  8  input state byte, column-major order, index i = 4*c + r.
REQ-007 in_ready  output  1  block accepts in_byte this cycle.
REQ-008 out_valid  output  1  out_byte carries a permuted byte.
REQ-009 out_byte  output  8  permuted state byte, column-major order.
REQ-010 out_ready  input  1  downstream accepts out_byte this cycle.
REQ-011 out_last  output  1  high while the current out_byte is output index 15 of a block.

Function
REQ-012 Storage: two 16-byte banks (ping-pong), each with a full flag; write bank pointer wbank, 4-bit write count wcnt; read bank pointer rbank, 4-bit read count rcnt.
REQ-013 in_ready = ~full[wbank]; input transfer = in_valid & in_ready.
REQ-014 On input transfer: bank[wbank][wcnt] <= in_byte; wcnt increments.
REQ-015 Input transfer at wcnt==15: full[wbank] set, wbank toggles, wcnt wraps to 0.
REQ-016 out_valid = full[rbank]; output transfer = out_valid & out_ready.
REQ-017 out_byte = bank[rbank][src(rcnt)], combinational from registered storage, with k = rcnt, r = k mod 4, c = k div 4.
REQ-018 With INVERSE=1: src(k) = 4*((c - r) mod 4) + r. With INVERSE=0: src(k) = 4*((c + r) mod 4) + r.
REQ-019 On output transfer: rcnt increments; at rcnt==15, full[rbank] clears, rbank toggles, rcnt wraps to 0.
REQ-020 out_last = out_valid & (rcnt==15).
REQ-021 Latency: out_valid rises in the cycle after the edge that accepts byte 15 of a block; out_byte then equals input byte 0.
REQ-022 Throughput: with in_valid and out_ready held high, one byte per cycle sustained in both directions, no bubbles after the first block.
REQ-023 Backpressure: with both banks full, in_ready = 0; input bytes are neither stored nor counted.
REQ-024 Simultaneous events: fill-complete on one bank and drain-complete on the other in the same cycle both take effect; a single bank is never set and cleared in the same cycle.
REQ-025 out_byte and out_last hold stable while out_valid=1 and out_ready=0.
REQ-026 rst_synch=1: same clear as reset at the next edge, overriding any transfer that cycle; bank contents are not cleared.

Reset
REQ-027 rst=1 forces wbank=0, rbank=0, wcnt=0, rcnt=0, full=2'b00 immediately, so in_ready=1, out_valid=0, out_last=0.
REQ-028 Reset or rst_synch mid-block discards any partial or unread block; output is never produced for it.
REQ-029 Bank storage is not reset; out_byte is don't-care while out_valid=0.

Verification
REQ-030 INVERSE=1, bytes 0..15 streamed, out_ready=1 -> outputs 0,13,10,7,4,1,14,11,8,5,2,15,12,9,6,3; out_valid is first high in the cycle after byte 15 is accepted; out_last is high only on byte 3.
REQ-031 INVERSE=0, same stimulus -> outputs 0,5,10,15,4,9,14,3,8,13,2,7,12,1,6,11.
REQ-032 Back-to-back: 3 blocks streamed continuously, out_ready=1 -> in_ready never drops; 48 outputs with no gaps after the first; each block permuted correctly.
REQ-033 out_ready=0 while 40 bytes are offered -> in_ready drops after 32 accepted bytes; out_valid=1 and out_byte held at 0; after release, both blocks drain in order and in_ready returns to 1.
REQ-034 rst pulse after 7 bytes of a block, then bytes 0x20..0x2F -> only the 0x20-based block is emitted, as 0x20,0x2D,0x2A,...,0x23.
REQ-035 rst_synch during an output transfer in the middle of a drain -> the next cycle shows out_valid=0 and in_ready=1; the transfer in the rst_synch cycle does not advance rcnt.

Source files
------------

// File: rtl/inv_byte_permutation_unit_if.sv
// Byte-stream bundle for the (inverse) ShiftRows permutation unit.
// master drives the input stream and output backpressure; slave is the unit itself.
interface inv_byte_permutation_unit_if;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       out_ready;
  logic       out_last;

  modport master (
    output in_valid, in_byte, out_ready,
    input  in_ready, out_valid, out_byte, out_last
  );

  modport slave (
    input  in_valid, in_byte, out_ready,
    output in_ready, out_valid, out_byte, out_last
  );
endinterface

// File: rtl/inv_byte_permutation_unit.sv
// Streaming AES (Inv)ShiftRows: collects 16-byte column-major blocks into a
// ping-pong buffer and replays each block in row-shifted order.
module inv_byte_permutation_unit #(
  parameter bit INVERSE = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rst_synch,
  inv_byte_permutation_unit_if.slave    bus
);

  logic [7:0] mem [0:1][0:15];
  logic [1:0] full;
  logic       wbank;
  logic       rbank;
  logic [3:0] wcnt;
  logic [3:0] rcnt;

  logic in_fire;
  logic out_fire;

  // Output index k = 4c + r reads the byte that sits in the same row, with
  // the column rotated by r; 2-bit arithmetic supplies the mod 4.
  function automatic logic [3:0] src_idx(input logic [3:0] k);
    logic [1:0] r;
    logic [1:0] c;
    logic [1:0] sc;
    r  = k[1:0];
    c  = k[3:2];
    sc = INVERSE ? (c - r) : (c + r);
    return {sc, r};
  endfunction

  assign bus.in_ready  = ~full[wbank];
  assign bus.out_valid = full[rbank];
  assign bus.out_byte  = mem[rbank][src_idx(rcnt)];
  assign bus.out_last  = full[rbank] & (rcnt == 4'd15);

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = full[rbank] & bus.out_ready;

  // NOTE: the data banks have no reset; a bank is only read once its full
  // flag proves all 16 bytes were written, so reset flops would buy nothing.
  always_ff @(posedge clk) begin
    if (in_fire && !rst_synch) begin
      mem[wbank][wcnt] <= bus.in_byte;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full  <= 2'b00;
      wbank <= 1'b0;
      rbank <= 1'b0;
      wcnt  <= 4'd0;
      rcnt  <= 4'd0;
    end else if (rst_synch) begin
      full  <= 2'b00;
      wbank <= 1'b0;
      rbank <= 1'b0;
      wcnt  <= 4'd0;
      rcnt  <= 4'd0;
    end else begin
      // Fill and drain never target the same bank: a filling bank is empty,
      // a draining bank is full.
      if (in_fire) begin
        wcnt <= wcnt + 4'd1;
        if (wcnt == 4'd15) begin
          full[wbank] <= 1'b1;
          wbank       <= ~wbank;
        end
      end
      if (out_fire) begin
        rcnt <= rcnt + 4'd1;
        if (rcnt == 4'd15) begin
          full[rbank] <= 1'b0;
          rbank       <= ~rbank;
        end
      end
    end
  end

endmodule
